// File: rtl/branch_result.sv
// -----------------------------------------------------------------------------
// branch_result
//
// Branch-resolution checker for the EX stage. Compares what the fetch-stage
// predictor assumed (taken flag + predicted target) with what the ALU actually
// resolved (taken flag + computed target). It produces a registered 2-bit
// verdict that the hazard / PC-select logic uses to keep or flush the pipeline
// and to choose the redirect PC.
//
// Verdict encoding (Result):
//   2'b00  prediction correct, no flush
//   2'b01  predicted not-taken, actually taken    -> flush, redirect to PC_ALU
//   2'b10  predicted taken, actually not-taken    -> flush, redirect to PC+4
//   2'b11  taken/taken but PC_Pre != PC_ALU       -> flush, redirect to PC_ALU
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset, forces Result to 00
//   Predicted  in   1      predictor said taken for this instruction
//   PC_Pre     in   WIDTH  predicted target carried down from fetch
//   PC_ALU     in   WIDTH  target computed by the ALU in EX
//   Execute    in   1      branch actually taken (resolved in EX)
//   Result     out  2      registered verdict, one cycle after the inputs
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module branch_result #(
  parameter int unsigned WIDTH_DATA_LENGTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         Predicted,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
  input  logic                         Execute,
  output logic [1:0]                   Result
);

  typedef enum logic [1:0] {
    VERDICT_OK         = 2'b00,
    VERDICT_MISS_TAKEN = 2'b01,
    VERDICT_MISS_NT    = 2'b10,
    VERDICT_BAD_TARGET = 2'b11
  } verdict_e;

  verdict_e result_d;
  verdict_e result_q;

  // Full-width target compare; only consulted when both sides agree on taken.
  logic target_match;
  assign target_match = (PC_Pre == PC_ALU);

  always_comb begin
    // NOTE: default first so every path assigns result_d and no latch is inferred.
    result_d = VERDICT_OK;
    // A plain case (not unique) lets X/Z on the control bits fall into the
    // default arm, so an undriven input never produces a spurious flush.
    case ({Predicted, Execute})
      2'b01:   result_d = VERDICT_MISS_TAKEN;
      2'b10:   result_d = VERDICT_MISS_NT;
      2'b11:   result_d = target_match ? VERDICT_OK : VERDICT_BAD_TARGET;
      default: result_d = VERDICT_OK;
    endcase
  end

  // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= VERDICT_OK;
    end else begin
      result_q <= result_d;
    end
  end

  assign Result = result_q;

endmodule

// File: tb/tb_branch_result.sv
`timescale 1ns/1ps

module tb_branch_result;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         Predicted;
  logic [W-1:0] PC_Pre;
  logic [W-1:0] PC_ALU;
  logic         Execute;
  logic [1:0]   Result;

  int errors = 0;
  int checks = 0;

  branch_result #(.WIDTH_DATA_LENGTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Predicted (Predicted),
    .PC_Pre    (PC_Pre),
    .PC_ALU    (PC_ALU),
    .Execute   (Execute),
    .Result    (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what the redirect decision should be, phrased as
  // "which kind of misprediction happened", independent of any encoding table.
  function automatic logic [1:0] model(input bit p, input bit e,
                                       input logic [W-1:0] pre, input logic [W-1:0] alu);
    bit direction_wrong;
    direction_wrong = (p != e);
    if (direction_wrong) return p ? 2'd2 : 2'd1;
    if (p && (pre != alu)) return 2'd3;
    return 2'd0;
  endfunction

  // Drive at the falling edge, check just after the following rising edge.
  task automatic step(input bit p, input bit e, input logic [W-1:0] pre,
                      input logic [W-1:0] alu, input string tag, input logic [1:0] exp);
    @(negedge clk);
    Predicted = p;
    Execute   = e;
    PC_Pre    = pre;
    PC_ALU    = alu;
    @(posedge clk);
    #1 check(tag, Result, exp);
  endtask

  initial begin
    logic [1:0] exp_q;
    bit         p, e;
    logic [W-1:0] pre, alu;

    // Unconfigured control inputs under reset.
    Predicted = 1'bx;
    Execute   = 1'bx;
    PC_Pre    = '0;
    PC_ALU    = '0;
    rst_n     = 1'b0;
    #1 check("reset_initial", Result, 2'b00);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("x_controls", Result, 2'b00);

    // Directed cases.
    step(1'b0, 1'b0, 32'h1234_0000, 32'h1234_0000, "nt_nt",        2'b00);
    step(1'b0, 1'b1, 32'h1234_0000, 32'h1234_0000, "nt_t",         2'b01);
    step(1'b1, 1'b1, 32'h1234_0000, 32'h1234_0000, "t_t_same",     2'b00);
    step(1'b1, 1'b1, 32'h1234_0000, 32'h1234_FFFF, "t_t_wrong",    2'b11);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, "t_t_msb_diff", 2'b11);
    step(1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFF0, "nt_t_pcdiff",  2'b01);
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, "t_nt",         2'b10);

    // Input change between edges must not reach the output until the edge.
    #2;
    Predicted = 1'b0;
    Execute   = 1'b1;
    #1 check("hold_between_edges", Result, 2'b10);
    @(posedge clk);
    #1 check("update_at_edge", Result, 2'b01);

    // Asynchronous reset mid-operation.
    step(1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, "pre_reset", 2'b10);
    #2 rst_n = 1'b0;
    #1 check("async_reset", Result, 2'b00);
    @(posedge clk);
    #1 check("reset_held_over_edge", Result, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_no_edge", Result, 2'b00);
    @(posedge clk);
    #1 check("first_after_reset", Result, 2'b10);

    // Back-to-back randomized verdicts: each one must appear one cycle later.
    @(negedge clk);
    exp_q = 2'b00;
    for (int i = 0; i < 300; i++) begin
      p   = 1'($urandom_range(0, 1));
      e   = 1'($urandom_range(0, 1));
      pre = $urandom;
      case ($urandom_range(0, 2))
        0:       alu = pre;
        1:       alu = pre ^ (32'h1 << $urandom_range(0, W - 1));
        default: alu = $urandom;
      endcase
      Predicted = p;
      Execute   = e;
      PC_Pre    = pre;
      PC_ALU    = alu;
      exp_q     = model(p, e, pre, alu);
      @(negedge clk);
      check("random", Result, exp_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
